// File: rtl/fetch_stage.sv
// RV32 instruction fetch stage: owns the PC, issues word requests to instruction
// memory, buffers in-order responses and feeds decode through the F/D register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  pc_sel_e,
   input  logic [31:0] alsu_res_e,
   input  logic        flush,
   input  logic        stall_d,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc4_d,
   output logic        valid_d
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0] pc_f;
   logic [31:0] infl_pc [2];
   logic [1:0]  infl_cnt;
   logic [1:0]  disc_cnt;
   logic [63:0] fifo_q [2];
   logic [1:0]  fifo_cnt;

   logic        fifo_pop;
   logic        req_fire;
   logic        rsp_keep;
   logic [2:0]  credits_used;
   logic [31:0] redirect_pc;
   logic [31:0] target_pc;
   logic [63:0] rsp_entry;

   // A pop this cycle frees a slot, so a full pipe can still issue every cycle.
   always_comb begin
      fifo_pop     = !flush && !stall_d && (fifo_cnt != 2'd0);
      credits_used = {1'b0, infl_cnt} + {1'b0, fifo_cnt} - {2'b00, fifo_pop};
      imem_req_valid = !rst && !flush && (credits_used < 3'd2);
      req_fire     = imem_req_valid && imem_req_ready;
      rsp_keep     = imem_rsp_valid && !flush && (disc_cnt == 2'd0);
      redirect_pc  = (pc_sel_e == 2'b10) ? {alsu_res_e[31:1], 1'b0} : alsu_res_e;
      target_pc    = redirect_pc & 32'hFFFF_FFFC;
      rsp_entry    = {infl_pc[0], imem_rsp_data};
      imem_addr    = pc_f;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_f <= RESET_PC;
      end else if (flush) begin
         pc_f <= target_pc;
      end else if (req_fire) begin
         pc_f <= pc_f + 32'd4;
      end
   end

   // In-flight PCs are kept across a flush so the response pops stay aligned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         infl_cnt   <= 2'd0;
         infl_pc[0] <= 32'h0;
         infl_pc[1] <= 32'h0;
      end else begin
         case ({req_fire, imem_rsp_valid})
            2'b10: begin
               infl_pc[infl_cnt[0]] <= pc_f;
               infl_cnt <= infl_cnt + 2'd1;
            end
            2'b01: begin
               infl_pc[0] <= infl_pc[1];
               infl_cnt <= infl_cnt - 2'd1;
            end
            2'b11: begin
               infl_pc[0] <= (infl_cnt == 2'd1) ? pc_f : infl_pc[1];
               infl_pc[1] <= pc_f;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disc_cnt <= 2'd0;
      end else if (flush) begin
         disc_cnt <= infl_cnt - {1'b0, imem_rsp_valid};
      end else if (imem_rsp_valid && (disc_cnt != 2'd0)) begin
         disc_cnt <= disc_cnt - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_cnt   <= 2'd0;
         fifo_q[0]  <= 64'h0;
         fifo_q[1]  <= 64'h0;
      end else if (flush) begin
         fifo_cnt <= 2'd0;
      end else begin
         case ({rsp_keep, fifo_pop})
            2'b10: begin
               fifo_q[fifo_cnt[0]] <= rsp_entry;
               fifo_cnt <= fifo_cnt + 2'd1;
            end
            2'b01: begin
               fifo_q[0] <= fifo_q[1];
               fifo_cnt <= fifo_cnt - 2'd1;
            end
            2'b11: begin
               fifo_q[0] <= (fifo_cnt == 2'd1) ? rsp_entry : fifo_q[1];
               fifo_q[1] <= rsp_entry;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_d <= 1'b0;
         instr_d <= NOP;
         pc_d    <= 32'h0;
         pc4_d   <= 32'h0;
      end else if (flush) begin
         valid_d <= 1'b0;
         instr_d <= NOP;
      end else if (!stall_d) begin
         if (fifo_pop) begin
            valid_d <= 1'b1;
            instr_d <= fifo_q[0][31:0];
            pc_d    <= fifo_q[0][63:32];
            pc4_d   <= fifo_q[0][63:32] + 32'd4;
         end else begin
            valid_d <= 1'b0;
         end
      end
   end

endmodule
